// File: rtl/hazard_redirect_ctrl.sv
// hazard_redirect_ctrl: stall/flush sequencing for the 5-stage RV32I pipeline.
// Resolves data-memory stalls, EX redirects and load-use hazards, in that
// order of priority, and drives every stage write enable and flush.
// Optional build macro: HAZARD_STATS_EN adds free-running event counters.
module hazard_redirect_ctrl #(
    parameter int IMEM_LAT = 1,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_target,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      ex_rd,
    input  logic            ex_mem_read,
    input  logic            dmem_req,
    input  logic            dmem_ready,
    output logic            pc_we,
    output logic            pc_sel,
    output logic [XLEN-1:0] pc_target,
    output logic            ifid_we,
    output logic            ifid_flush,
    output logic            idex_we,
    output logic            idex_flush,
    output logic            exmem_we,
    output logic [1:0]      ctrl_state
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]     redirect_cnt,
    output logic [31:0]     lu_stall_cnt,
    output logic [31:0]     mem_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_LU_STALL = 2'd2,
        ST_MEM_WAIT = 2'd3
    } state_e;

    state_e     state_q, state_d;
    state_e     saved_state_q, saved_state_d;
    state_e     eff_state;
    logic [2:0] flush_cnt_q, flush_cnt_d;

    logic mem_stall;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic redirect_go;
    logic lu_go;

    // While waiting on memory the cycle is judged as the state we stalled in.
    assign eff_state   = (state_q == ST_MEM_WAIT) ? saved_state_q : state_q;
    assign mem_stall   = dmem_req & ~dmem_ready;
    assign rs1_hit     = id_use_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit     = id_use_rs2 & (id_rs2 == ex_rd);
    assign load_use    = ex_mem_read & (ex_rd != 5'd0) & (rs1_hit | rs2_hit)
                         & (eff_state == ST_RUN);
    assign redirect_go = ~mem_stall & ex_redirect;
    assign lu_go       = ~mem_stall & ~ex_redirect & load_use;
    assign ctrl_state  = state_q;

    // State register, saved pre-stall state and post-redirect flush counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            saved_state_q <= ST_RUN;
            flush_cnt_q   <= 3'd0;
        end else begin
            state_q       <= state_d;
            saved_state_q <= saved_state_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    // Next-state selection: memory stall freezes everything, then redirect, then load-use.
    always_comb begin
        state_d       = state_q;
        saved_state_d = saved_state_q;
        flush_cnt_d   = flush_cnt_q;
        if (mem_stall) begin
            state_d       = ST_MEM_WAIT;
            saved_state_d = eff_state;
        end else if (ex_redirect) begin
            if (IMEM_LAT > 0) begin
                state_d     = ST_FLUSH;
                flush_cnt_d = 3'(IMEM_LAT);
            end else begin
                state_d     = ST_RUN;
                flush_cnt_d = 3'd0;
            end
        end else begin
            case (eff_state)
                ST_FLUSH: begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                    state_d     = (flush_cnt_q == 3'd1) ? ST_RUN : ST_FLUSH;
                end
                ST_LU_STALL: state_d = ST_RUN;
                ST_RUN:      state_d = load_use ? ST_LU_STALL : ST_RUN;
                default:     state_d = ST_RUN;
            endcase
        end
    end

    // Stage enables and flushes; reset forces bubbles into IF/ID and ID/EX.
    always_comb begin
        pc_we      = 1'b1;
        pc_sel     = 1'b0;
        pc_target  = '0;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_we    = 1'b1;
        idex_flush = 1'b0;
        exmem_we   = 1'b1;
        if (!rst_n) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_we    = 1'b0;
            exmem_we   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (mem_stall) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
        end else if (ex_redirect) begin
            pc_sel     = 1'b1;
            pc_target  = ex_target;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (eff_state == ST_FLUSH) begin
            ifid_flush = 1'b1;
        end else if (load_use) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] redirect_cnt_q, redirect_cnt_d;
    logic [31:0] lu_stall_cnt_q, lu_stall_cnt_d;
    logic [31:0] mem_stall_cnt_q, mem_stall_cnt_d;

    // One count per cycle of each acted-upon event; wraps naturally at 2^32.
    always_comb begin
        redirect_cnt_d  = redirect_cnt_q + {31'd0, redirect_go};
        lu_stall_cnt_d  = lu_stall_cnt_q + {31'd0, lu_go};
        mem_stall_cnt_d = mem_stall_cnt_q + {31'd0, mem_stall};
    end

    // Event counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt_q  <= 32'd0;
            lu_stall_cnt_q  <= 32'd0;
            mem_stall_cnt_q <= 32'd0;
        end else begin
            redirect_cnt_q  <= redirect_cnt_d;
            lu_stall_cnt_q  <= lu_stall_cnt_d;
            mem_stall_cnt_q <= mem_stall_cnt_d;
        end
    end

    assign redirect_cnt  = redirect_cnt_q;
    assign lu_stall_cnt  = lu_stall_cnt_q;
    assign mem_stall_cnt = mem_stall_cnt_q;
`else
    logic unused_events;
    assign unused_events = redirect_go ^ lu_go;
`endif

endmodule

// File: tb/tb_hazard_redirect_ctrl.sv
// Directed bench for hazard_redirect_ctrl (IMEM_LAT=1, XLEN=32).
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_hazard_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_redirect = 1'b0;
    logic [31:0] ex_target = 32'd0;
    logic [4:0]  id_rs1 = 5'd0;
    logic [4:0]  id_rs2 = 5'd0;
    logic        id_use_rs1 = 1'b0;
    logic        id_use_rs2 = 1'b0;
    logic [4:0]  ex_rd = 5'd0;
    logic        ex_mem_read = 1'b0;
    logic        dmem_req = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        pc_we, pc_sel, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we;
    logic [31:0] pc_target;
    logic [1:0]  ctrl_state;
`ifdef HAZARD_STATS_EN
    logic [31:0] redirect_cnt, lu_stall_cnt, mem_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Packed enables: {pc_we, pc_sel, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we}
    localparam logic [6:0] V_RUN   = 7'b1010101;
    localparam logic [6:0] V_STALL = 7'b0000000;
    localparam logic [6:0] V_RESET = 7'b0001010;

    hazard_redirect_ctrl #(.IMEM_LAT(1), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_redirect(ex_redirect), .ex_target(ex_target),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_we(pc_we), .pc_sel(pc_sel), .pc_target(pc_target),
        .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_we(idex_we), .idex_flush(idex_flush),
        .exmem_we(exmem_we), .ctrl_state(ctrl_state)
`ifdef HAZARD_STATS_EN
        , .redirect_cnt(redirect_cnt), .lu_stall_cnt(lu_stall_cnt),
        .mem_stall_cnt(mem_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] enVec();
        return {pc_we, pc_sel, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic redir, input logic [31:0] tgt,
                                 input logic mrd, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2,
                                 input logic req, input logic rdy);
        @(negedge clk);
        ex_redirect = redirect_in(redir);
        ex_target   = tgt;
        ex_mem_read = mrd;
        ex_rd       = rd;
        id_rs1      = rs1;
        id_use_rs1  = u1;
        id_rs2      = rs2;
        id_use_rs2  = u2;
        dmem_req    = req;
        dmem_ready  = rdy;
        #1;
    endtask

    function automatic logic redirect_in(input logic r);
        return r;
    endfunction

    task automatic idle();
        applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        $display("[TB] start");
        #2;
        checkOutput("reset_vec", 32'(enVec()), 32'(V_RESET));
        checkOutput("reset_state", 32'(ctrl_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: redirect from RUN
        applyStimulus(1'b1, 32'h100, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_c0_pc_sel", 32'(pc_sel), 32'd1);
        checkOutput("t1_c0_target", pc_target, 32'h100);
        checkOutput("t1_c0_pc_we", 32'(pc_we), 32'd1);
        checkOutput("t1_c0_ifid_flush", 32'(ifid_flush), 32'd1);
        checkOutput("t1_c0_idex_flush", 32'(idex_flush), 32'd1);
        checkOutput("t1_c0_exmem_we", 32'(exmem_we), 32'd1);
        idle();
        checkOutput("t1_c1_state", 32'(ctrl_state), 32'd1);
        checkOutput("t1_c1_vec", 32'(enVec()), 32'(7'b1011101));
        checkOutput("t1_c1_target", pc_target, 32'd0);
        idle();
        checkOutput("t1_c2_state", 32'(ctrl_state), 32'd0);
        checkOutput("t1_c2_vec", 32'(enVec()), 32'(V_RUN));

        // T2: load-use on rs1, then x0 never stalls
        applyStimulus(1'b0, 32'd0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_c0_pc_we", 32'(pc_we), 32'd0);
        checkOutput("t2_c0_ifid_we", 32'(ifid_we), 32'd0);
        checkOutput("t2_c0_idex_flush", 32'(idex_flush), 32'd1);
        checkOutput("t2_c0_exmem_we", 32'(exmem_we), 32'd1);
        checkOutput("t2_c0_ifid_flush", 32'(ifid_flush), 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_c1_state", 32'(ctrl_state), 32'd2);
        checkOutput("t2_c1_vec", 32'(enVec()), 32'(V_RUN));
        idle();
        checkOutput("t2_c2_state", 32'(ctrl_state), 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("t2_x0_vec", 32'(enVec()), 32'(V_RUN));
        idle();
        checkOutput("t2_x0_state", 32'(ctrl_state), 32'd0);

        // T3: three memory stall cycles then completion
        applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("t3_c0_vec", 32'(enVec()), 32'(V_STALL));
        applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("t3_c1_vec", 32'(enVec()), 32'(V_STALL));
        checkOutput("t3_c1_state", 32'(ctrl_state), 32'd3);
        applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("t3_c2_vec", 32'(enVec()), 32'(V_STALL));
        checkOutput("t3_c2_state", 32'(ctrl_state), 32'd3);
        applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("t3_c3_vec", 32'(enVec()), 32'(V_RUN));
        checkOutput("t3_c3_state", 32'(ctrl_state), 32'd3);
        idle();
        checkOutput("t3_c4_state", 32'(ctrl_state), 32'd0);
        checkOutput("t3_c4_vec", 32'(enVec()), 32'(V_RUN));
`ifdef HAZARD_STATS_EN
        checkOutput("t6_redirect_cnt", redirect_cnt, 32'd1);
        checkOutput("t6_lu_stall_cnt", lu_stall_cnt, 32'd1);
        checkOutput("t6_mem_stall_cnt", mem_stall_cnt, 32'd3);
`endif

        // Load-use through rs2; matching rs2 that is not read does not stall
        applyStimulus(1'b0, 32'd0, 1'b1, 5'd7, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
        checkOutput("rs2_unused_vec", 32'(enVec()), 32'(V_RUN));
        applyStimulus(1'b0, 32'd0, 1'b1, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        checkOutput("rs2_stall_pc_we", 32'(pc_we), 32'd0);
        idle();
        checkOutput("rs2_stall_state", 32'(ctrl_state), 32'd2);

        // Memory stall while in FLUSH resumes the flush after dmem_ready
        applyStimulus(1'b1, 32'h300, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("fm_redirect_target", pc_target, 32'h300);
        applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("fm_stall_vec", 32'(enVec()), 32'(V_STALL));
        checkOutput("fm_stall_state", 32'(ctrl_state), 32'd1);
        applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("fm_resume_vec", 32'(enVec()), 32'(7'b1011101));
        idle();
        checkOutput("fm_done_state", 32'(ctrl_state), 32'd0);

        // T4: redirect beats a simultaneous load-use
        applyStimulus(1'b1, 32'h200, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_pc_sel", 32'(pc_sel), 32'd1);
        checkOutput("t4_pc_we", 32'(pc_we), 32'd1);
        checkOutput("t4_target", pc_target, 32'h200);
        checkOutput("t4_flushes", 32'({ifid_flush, idex_flush}), 32'd3);
        idle();
        checkOutput("t4_next_state", 32'(ctrl_state), 32'd1);

        // Redirect during FLUSH restarts with the new target
        applyStimulus(1'b1, 32'h600, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("rf_target", pc_target, 32'h600);
        checkOutput("rf_pc_sel", 32'(pc_sel), 32'd1);
        idle();
        checkOutput("rf_state_flush", 32'(ctrl_state), 32'd1);
        idle();
        checkOutput("rf_state_run", 32'(ctrl_state), 32'd0);

        // T5: redirect held during MEM_WAIT, then reset while in FLUSH
        applyStimulus(1'b1, 32'h400, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_w0_pc_sel", 32'(pc_sel), 32'd0);
        checkOutput("t5_w0_vec", 32'(enVec()), 32'(V_STALL));
        applyStimulus(1'b1, 32'h400, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_w1_pc_sel", 32'(pc_sel), 32'd0);
        checkOutput("t5_w1_state", 32'(ctrl_state), 32'd3);
        applyStimulus(1'b1, 32'h400, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("t5_ready_pc_sel", 32'(pc_sel), 32'd1);
        checkOutput("t5_ready_target", pc_target, 32'h400);
        idle();
        checkOutput("t5_flush_state", 32'(ctrl_state), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_vec", 32'(enVec()), 32'(V_RESET));
        checkOutput("t5_rst_state", 32'(ctrl_state), 32'd0);
        checkOutput("t5_rst_target", pc_target, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        checkOutput("t5_after_rst_vec", 32'(enVec()), 32'(V_RUN));
        checkOutput("t5_after_rst_state", 32'(ctrl_state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
